// File: rtl/regwr_pkg.sv
// rtl/regwr_pkg.sv - shared widths and late-result entry type for the register write-port controller
package regwr_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } late_entry_t;
endpackage

// File: rtl/regwr_fifo.sv
// rtl/regwr_fifo.sv - late-result circular buffer with squash-by-rd (REGWRITE_PENDING_EN adds rd bitmap)
module regwr_fifo
  import regwr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  late_entry_t           push_entry,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [REG_ADDR_W-1:0] squash_rd,
  output logic                  full,
  output logic                  empty,
  output late_entry_t           head,
  output logic [31:0]           pend_mask
);
  localparam int PTR_W = $clog2(DEPTH);

  late_entry_t      mem_q [DEPTH];
  late_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // valid=0 marks both free and squashed slots; occupancy is tracked by count_q
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (squash_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rd == squash_rd) mem_d[i].valid = 1'b0;
      end
    end
    if (pop) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      if (squash_en && (push_entry.rd == squash_rd)) mem_d[wr_ptr_q].valid = 1'b0;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef REGWRITE_PENDING_EN
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && (mem_q[i].rd != REG_ZERO)) pend_mask[mem_q[i].rd] = 1'b1;
    end
  end
`else
  assign pend_mask = '0;
`endif
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// rtl/regfile_writeback_ctrl.sv - register file write-port arbiter; REGWRITE_PENDING_EN enables pending_mask tracking
module regfile_writeback_ctrl
  import regwr_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_memtoreg,
  input  logic [DATA_W-1:0]     wb_memdata,
  input  logic [DATA_W-1:0]     wb_aluout,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0]     lu_data,
  output logic                  pipe_stall,
  output logic [REG_ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0]     writedata,
  output logic                  regwrite,
  output logic [31:0]           pending_mask
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  logic                  fifo_full, fifo_empty, push, pop, squash_en;
  late_entry_t           fifo_head, push_entry;
  logic [31:0]           fifo_mask;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] writereg_q, writereg_d;
  logic [DATA_W-1:0]     writedata_q, writedata_d;

  assign lu_ready   = !fifo_full;
  assign push       = lu_valid && !fifo_full;
  assign push_entry = '{valid: 1'b1, rd: lu_rd, data: lu_data};
  assign pipe_stall = (starve_q == STARVE_LAST) && !fifo_empty;

  regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash_en  (squash_en),
    .squash_rd  (wb_rd),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .pend_mask  (fifo_mask)
  );

  always_comb begin
    pop         = 1'b0;
    squash_en   = 1'b0;
    regwrite_d  = 1'b0;
    writereg_d  = REG_ZERO;
    writedata_d = '0;
    if (pipe_stall || (!wb_valid && !fifo_empty)) begin
      pop = 1'b1;
      if (fifo_head.valid && (fifo_head.rd != REG_ZERO)) begin
        regwrite_d  = 1'b1;
        writereg_d  = fifo_head.rd;
        writedata_d = fifo_head.data;
      end
    end else if (wb_valid) begin
      squash_en = 1'b1;
      if (wb_rd != REG_ZERO) begin
        regwrite_d  = 1'b1;
        writereg_d  = wb_rd;
        writedata_d = wb_memtoreg ? wb_memdata : wb_aluout;
      end
    end
    // a squashed head leaves the queue but earns no starvation credit
    if (fifo_empty || (pop && fifo_head.valid)) starve_d = '0;
    else if (starve_q != STARVE_LAST)           starve_d = starve_q + 1'b1;
    else                                        starve_d = starve_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= REG_ZERO;
      writedata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  assign regwrite  = regwrite_q;
  assign writereg  = writereg_q;
  assign writedata = writedata_q;

`ifdef REGWRITE_PENDING_EN
  assign pending_mask = fifo_mask | (regwrite_q ? (32'd1 << writereg_q) : 32'd0);
`else
  assign pending_mask = fifo_mask;
`endif
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// tb/tb_regfile_writeback_ctrl.sv - vector table, corner sequences and random run against a queue model
module tb_regfile_writeback_ctrl;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic        clk = 1'b0;
  logic        rst_n, wb_valid, wb_memtoreg, lu_valid;
  logic [4:0]  wb_rd, lu_rd;
  logic [31:0] wb_memdata, wb_aluout, lu_data;
  logic        lu_ready, pipe_stall, regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata, pending_mask;

  regfile_writeback_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_memtoreg(wb_memtoreg),
    .wb_memdata(wb_memdata), .wb_aluout(wb_aluout), .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_rd(lu_rd), .lu_data(lu_data), .pipe_stall(pipe_stall), .writereg(writereg),
    .writedata(writedata), .regwrite(regwrite), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: queue of pending late results, each alive until overwritten by a newer pipeline write
  typedef struct { int rd; logic [31:0] data; bit live; } ment_t;
  ment_t       mq[$];
  int          m_starve = 0;
  bit          m_we = 0;
  int          m_rd = 0;
  logic [31:0] m_data = 0;
  logic [31:0] m_pend = 0;

  function automatic bit m_stall();
    return (m_starve == SMAX - 1) && (mq.size() > 0);
  endfunction

  function automatic void model_step();
    bit    was_empty, stall, accept, drained, wbslot;
    ment_t e;
    if (!rst_n) begin
      mq.delete();
      m_starve = 0; m_we = 0; m_rd = 0; m_data = 0;
    end else begin
      was_empty = (mq.size() == 0);
      stall     = m_stall();
      accept    = lu_valid && (mq.size() < DEPTH);
      drained   = 0;
      wbslot    = 0;
      m_we = 0; m_rd = 0; m_data = 0;
      if (stall || (!wb_valid && !was_empty)) begin
        e = mq.pop_front();
        if (e.live) begin
          drained = 1;
          if (e.rd != 0) begin m_we = 1; m_rd = e.rd; m_data = e.data; end
        end
      end else if (wb_valid) begin
        wbslot = 1;
        if (wb_rd != 0) begin
          m_we = 1; m_rd = int'(wb_rd); m_data = wb_memtoreg ? wb_memdata : wb_aluout;
        end
        foreach (mq[i]) if (mq[i].rd == int'(wb_rd)) mq[i].live = 0;
      end
      if (accept) mq.push_back('{rd: int'(lu_rd), data: lu_data, live: !(wbslot && lu_rd == wb_rd)});
      if (was_empty || drained) m_starve = 0;
      else m_starve = (m_starve + 1 > SMAX - 1) ? SMAX - 1 : m_starve + 1;
    end
    m_pend = 0;
`ifdef REGWRITE_PENDING_EN
    foreach (mq[i]) if (mq[i].live && mq[i].rd != 0) m_pend[mq[i].rd] = 1'b1;
    if (m_we) m_pend[m_rd] = 1'b1;
`endif
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_memtoreg = 0; wb_memdata = 0; wb_aluout = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  typedef struct {
    int wbv, wrd, m2r; logic [31:0] mem, alu;
    int luv, lrd;      logic [31:0] ld;
    int rdy, stl, we, ord; logic [31:0] od;
  } vec_t;
  vec_t tbl[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 5, 0, 32'hDEAD, 32'h1234, 0, 0, 0,      1, 0, 1, 5,  32'h1234};
    tbl[1]  = '{1, 6, 1, 32'hCAFE, 32'h1,    0, 0, 0,      1, 0, 1, 6,  32'hCAFE};
    tbl[2]  = '{0, 0, 0, 0, 0,               1, 7, 32'hAA, 1, 0, 0, 0,  0};
    tbl[3]  = '{0, 0, 0, 0, 0,               0, 0, 0,      1, 0, 1, 7,  32'hAA};
    tbl[4]  = '{1, 9, 0, 0, 32'h2,           1, 9, 32'h1,  1, 0, 1, 9,  32'h2};
    tbl[5]  = '{0, 0, 0, 0, 0,               0, 0, 0,      1, 0, 0, 0,  0};
    tbl[6]  = '{0, 0, 0, 0, 0,               1, 1, 32'h11, 1, 0, 0, 0,  0};
    tbl[7]  = '{1, 3, 0, 0, 32'h33,          1, 2, 32'h22, 1, 0, 1, 3,  32'h33};
    tbl[8]  = '{1, 10, 0, 0, 32'h100,        1, 4, 32'h44, 1, 0, 1, 10, 32'h100};
    tbl[9]  = '{1, 11, 0, 0, 32'h111,        1, 0, 32'h55, 1, 0, 1, 11, 32'h111};
    tbl[10] = '{1, 13, 0, 0, 32'h133,        1, 12, 32'h66, 0, 0, 1, 13, 32'h133};
    tbl[11] = '{0, 0, 0, 0, 0,               1, 12, 32'h66, 0, 0, 1, 1,  32'h11};
    tbl[12] = '{0, 0, 0, 0, 0,               1, 12, 32'h66, 1, 0, 1, 2,  32'h22};
    tbl[13] = '{0, 0, 0, 0, 0,               0, 0, 0,      1, 0, 1, 4,  32'h44};
    tbl[14] = '{0, 0, 0, 0, 0,               0, 0, 0,      1, 0, 0, 0,  0};
    tbl[15] = '{0, 0, 0, 0, 0,               0, 0, 0,      1, 0, 1, 12, 32'h66};
    tbl[16] = '{0, 0, 0, 0, 0,               0, 0, 0,      1, 0, 0, 0,  0};

    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    chk("reset_regwrite", 32'(regwrite), 0);
    chk("reset_writereg", 32'(writereg), 0);
    chk("reset_writedata", writedata, 0);
    chk("reset_lu_ready", 32'(lu_ready), 1);
    chk("reset_pipe_stall", 32'(pipe_stall), 0);
    chk("reset_pending", pending_mask, 0);

    for (int i = 0; i < 17; i++) begin
      wb_valid = tbl[i].wbv[0]; wb_rd = 5'(tbl[i].wrd); wb_memtoreg = tbl[i].m2r[0];
      wb_memdata = tbl[i].mem; wb_aluout = tbl[i].alu;
      lu_valid = tbl[i].luv[0]; lu_rd = 5'(tbl[i].lrd); lu_data = tbl[i].ld;
      chk($sformatf("vec%0d_lu_ready", i), 32'(lu_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_pipe_stall", i), 32'(pipe_stall), 32'(tbl[i].stl));
      tick();
      chk($sformatf("vec%0d_regwrite", i), 32'(regwrite), 32'(tbl[i].we));
      chk($sformatf("vec%0d_writereg", i), 32'(writereg), 32'(tbl[i].ord));
      chk($sformatf("vec%0d_writedata", i), writedata, tbl[i].od);
    end
    idle();

    // starvation: one queued entry against a continuous pipeline write stream
    lu_valid = 1; lu_rd = 5'd20; lu_data = 32'h2020;
    tick();
    chk("starve_push_regwrite", 32'(regwrite), 0);
    idle();
    wb_valid = 1; wb_rd = 5'd21; wb_aluout = 32'h2121;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("starve_c%0d_pipe_stall", k), 32'(pipe_stall), (k == 8) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("starve_c%0d_regwrite", k), 32'(regwrite), 1);
      chk($sformatf("starve_c%0d_writereg", k), 32'(writereg), (k == 8) ? 32'd20 : 32'd21);
      chk($sformatf("starve_c%0d_writedata", k), writedata, (k == 8) ? 32'h2020 : 32'h2121);
    end
    idle();

    // rd0 pipeline writes while three entries queue, then reset discards them
    wb_valid = 1; wb_rd = 5'd0; wb_aluout = 32'hBAD0;
    for (int k = 0; k < 3; k++) begin
      lu_valid = 1; lu_rd = 5'(14 + k); lu_data = 32'(32'h140 + k);
      tick();
      chk($sformatf("rd0_c%0d_regwrite", k), 32'(regwrite), 0);
    end
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midreset_regwrite", 32'(regwrite), 0);
    chk("midreset_writereg", 32'(writereg), 0);
    chk("midreset_writedata", writedata, 0);
    chk("midreset_pending", pending_mask, 0);
    chk("midreset_lu_ready", 32'(lu_ready), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("postreset_c%0d_regwrite", k), 32'(regwrite), 0);
    end

    // randomized traffic against the queue model
    for (int n = 0; n < 4000; n++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      wb_valid    = ($urandom_range(0, 9) < 7);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_memtoreg = $urandom_range(0, 1) != 0;
      wb_memdata  = $urandom;
      wb_aluout   = $urandom;
      lu_valid    = ($urandom_range(0, 9) < 5);
      lu_rd       = 5'($urandom_range(0, 7));
      lu_data     = $urandom;
      chk("rand_lu_ready", 32'(lu_ready), (mq.size() < DEPTH) ? 32'd1 : 32'd0);
      chk("rand_pipe_stall", 32'(pipe_stall), 32'(m_stall()));
      tick();
      chk("rand_regwrite", 32'(regwrite), 32'(m_we));
      chk("rand_writereg", 32'(writereg), 32'(m_rd));
      chk("rand_writedata", writedata, m_data);
      chk("rand_pending", pending_mask, m_pend);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
